interval_timer_arbiter: RTL

Two-requester controller that shares one WIDTH-bit up-counter between independent clients. Each client requests a timed interval through a valid/ready handshake. A round-robin arbiter grants the counter to one client at a time. The counter runs from 0 up to the requested length, and a one-cycle done pulse is returned to the owning client. The block sits between interval-timing clients and the shared counter datapath.

---
 rtl/interval_timer_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/interval_timer_arbiter.sv
// interval_timer_arbiter
//
// Shares one WIDTH-bit up-counter between two interval-timing clients.
// Each client asks for an interval with a valid/ready handshake. A
// round-robin arbiter grants the counter to one client at a time. The
// counter then runs from 0 up to the latched length. The owning client
// gets a one-cycle done pulse when the interval ends. An abort during RUN
// cancels the interval and raises a one-cycle aborted pulse instead.
//
// State table:
//   state | meaning
//   IDLE  | counter free, count held at 0, arbitrating pending requests
//   RUN   | counter owned by 'owner', counting 0 .. len_q
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   [1:0] pending request per client
//   req_len0   in   [WIDTH-1:0] terminal count requested by client 0
//   req_len1   in   [WIDTH-1:0] terminal count requested by client 1
//   req_ready  out  [1:0] request accepted this cycle (combinational)
//   abort      in   cancel the running interval (ignored in IDLE)
//   busy       out  counter owned (state RUN)
//   owner      out  current / last granted client
//   count      out  [WIDTH-1:0] shared counter value
//   done       out  [1:0] one-cycle completion pulse to the owner
//   aborted    out  one-cycle pulse when a running interval is cancelled

module interval_timer_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   input  logic [WIDTH-1:0] req_len0,
   input  logic [WIDTH-1:0] req_len1,
   output logic [1:0]       req_ready,
   input  logic             abort,
   output logic             busy,
   output logic             owner,
   output logic [WIDTH-1:0] count,
   output logic [1:0]       done,
   output logic             aborted
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] len_q;
   logic             prio;
   logic             grant;
   logic             handshake;

   // Winner selection: a lone requester wins outright; a tie goes to prio.
   always_comb begin
      grant = 1'b0;
      if (req_valid == 2'b11) begin
         grant = prio;
      end else if (req_valid[1]) begin
         grant = 1'b1;
      end
   end

   always_comb begin
      req_ready = 2'b00;
      if (state == IDLE && req_valid != 2'b00) begin
         req_ready = grant ? 2'b10 : 2'b01;
      end
   end

   assign handshake = |(req_valid & req_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= '0;
         len_q   <= '0;
         owner   <= 1'b0;
         prio    <= 1'b0;
         done    <= 2'b00;
         aborted <= 1'b0;
         busy    <= 1'b0;
      end else begin
         done    <= 2'b00;
         aborted <= 1'b0;
         case (state)
            IDLE: begin
               count <= '0;
               if (handshake) begin
                  len_q <= grant ? req_len1 : req_len0;
                  owner <= grant;
                  prio  <= ~grant;
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               // Abort takes precedence over a completion in the same cycle.
               if (abort) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  count   <= '0;
                  aborted <= 1'b1;
               end else if (count == len_q) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  count <= '0;
                  done  <= owner ? 2'b10 : 2'b01;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               count <= '0;
            end
         endcase
      end
   end

endmodule
